mem_wb_pipeline: RTL and testbench

//  EX/MEM and MEM/WB pipeline registers, data-memory access sequencing and load-use hazard detection.

---
 rtl/mem_wb_pipeline_pkg.sv | 22 ++
 rtl/mem_access_fsm.sv | 45 ++++
 rtl/mem_wb_pipeline.sv | 157 +++++++++++++++
 tb/tb_mem_wb_pipeline.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipeline_pkg.sv
// Shared constants and FSM encoding for the EX/MEM and MEM/WB backend slice.
package mem_wb_pipeline_pkg;

  localparam int WB_REGWRITE_BIT = 2;
  localparam int M_READ_BIT      = 1;
  localparam int M_WRITE_BIT     = 0;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // M=11 is illegal and behaves as a store, so only a pure read is a load.
  function automatic logic is_load(input logic [1:0] m);
    return m[M_READ_BIT] && !m[M_WRITE_BIT];
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake sequencer: issues dmem_req and stalls the backend until dmem_ready.
module mem_access_fsm
  import mem_wb_pipeline_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic access,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic mem_stall
);

  mem_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= MEM_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (access && !dmem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready)            state_nxt = MEM_IDLE;
      default:                             state_nxt = MEM_IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    case (state)
      MEM_IDLE: begin
        dmem_req  = access;
        mem_stall = access && !dmem_ready;
      end
      MEM_WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = !dmem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipeline.sv
// EX/MEM + MEM/WB pipeline registers, memory sequencing and load-use detection.
// Optional BACKEND_PERF_CNT_EN adds stall-cycle counters perf_mem_wait / perf_load_use.
module mem_wb_pipeline
  import mem_wb_pipeline_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
`ifdef BACKEND_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd_addr,
  input  logic [2:0]      ex_WB,
  input  logic [1:0]      ex_M,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_pc4,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [RA_W-1:0] mem_rd_addr,
  output logic [2:0]      mem_WB,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [RA_W-1:0] wb_rd_addr,
  output logic [2:0]      wb_WB,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            mem_stall,
  output logic            load_use_stall
`ifdef BACKEND_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_mem_wait
  , output logic [CNT_W-1:0] perf_load_use
`endif
);

  logic            mem_valid;
  logic [RA_W-1:0] mem_rd;
  logic [2:0]      mem_wb;
  logic [1:0]      mem_m;
  logic [XLEN-1:0] mem_alu, mem_rs2, mem_pc4;

  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic [2:0]      wb_wb;
  logic [XLEN-1:0] wb_alu, wb_pc4, wb_rdata;

  logic access, mem_advance;

  // EX/MEM: frozen while memory waits; invalid EX enters as a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_wb    <= '0;
      mem_m     <= '0;
      mem_alu   <= '0;
      mem_rs2   <= '0;
      mem_pc4   <= '0;
    end else if (!mem_stall) begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd_addr;
      mem_wb    <= ex_valid ? ex_WB : 3'b000;
      mem_m     <= ex_valid ? ex_M  : 2'b00;
      mem_alu   <= ex_alu_result;
      mem_rs2   <= ex_rs2_data;
      mem_pc4   <= ex_pc4;
    end
  end

  assign access      = mem_valid && (|mem_m);
  assign mem_advance = mem_valid && !mem_stall;

  mem_access_fsm u_fsm (
    .clk       (clk),
    .rstn      (rstn),
    .access    (access),
    .dmem_ready(dmem_ready),
    .dmem_req  (dmem_req),
    .mem_stall (mem_stall)
  );

  assign dmem_we    = dmem_req && mem_m[M_WRITE_BIT];
  assign dmem_addr  = mem_alu;
  assign dmem_wdata = mem_rs2;

  // MEM/WB: a stalled MEM stage sends a bubble so WB never repeats a write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_wb    <= '0;
      wb_alu   <= '0;
      wb_pc4   <= '0;
      wb_rdata <= '0;
    end else if (mem_stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= mem_valid;
      wb_rd    <= mem_rd;
      wb_wb    <= mem_wb;
      wb_alu   <= mem_alu;
      wb_pc4   <= mem_pc4;
      if (mem_advance && is_load(mem_m)) wb_rdata <= dmem_rdata;
    end
  end

  assign mem_rd_addr    = mem_rd;
  assign mem_WB         = {mem_wb[WB_REGWRITE_BIT] & mem_valid, mem_wb[1:0]};
  assign mem_alu_result = mem_alu;
  assign wb_rd_addr     = wb_rd;
  assign wb_WB          = {wb_wb[WB_REGWRITE_BIT] & wb_valid, wb_wb[1:0]};

  always_comb begin
    wb_rd_data = wb_alu;
    case (wb_wb[1:0])
      WB_SEL_ALU: wb_rd_data = wb_alu;
      WB_SEL_MEM: wb_rd_data = wb_rdata;
      WB_SEL_PC4: wb_rd_data = wb_pc4;
      default:    wb_rd_data = wb_alu;
    endcase
  end

  assign rf_we    = wb_WB[WB_REGWRITE_BIT] && (wb_rd != '0);
  assign rf_waddr = wb_rd;
  assign rf_wdata = wb_rd_data;

  // A memory wait already freezes the front end, so it overrides load-use.
  always_comb begin
    load_use_stall = ex_valid && ex_M[M_READ_BIT] && ex_WB[WB_REGWRITE_BIT] &&
                     (ex_rd_addr != '0) &&
                     ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr)) &&
                     !mem_stall;
  end

`ifdef BACKEND_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_mem_wait <= '0;
      perf_load_use <= '0;
    end else begin
      if (mem_stall)      perf_mem_wait <= perf_mem_wait + 1'b1;
      if (load_use_stall) perf_load_use <= perf_load_use + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipeline.sv
// Directed bench for mem_wb_pipeline with hand-computed expectations.
module tb_mem_wb_pipeline;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            ex_valid;
  logic [RA_W-1:0] ex_rd_addr;
  logic [2:0]      ex_WB;
  logic [1:0]      ex_M;
  logic [XLEN-1:0] ex_alu_result, ex_rs2_data, ex_pc4;
  logic [RA_W-1:0] id_rs1_addr, id_rs2_addr;
  logic            dmem_req, dmem_we, dmem_ready;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [RA_W-1:0] mem_rd_addr, wb_rd_addr, rf_waddr;
  logic [2:0]      mem_WB, wb_WB;
  logic [XLEN-1:0] mem_alu_result, wb_rd_data, rf_wdata;
  logic            rf_we, mem_stall, load_use_stall;
`ifdef BACKEND_PERF_CNT_EN
  logic [31:0]     perf_mem_wait, perf_load_use;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipeline #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_WB(ex_WB), .ex_M(ex_M),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_pc4(ex_pc4),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_rd_addr(mem_rd_addr), .mem_WB(mem_WB), .mem_alu_result(mem_alu_result),
    .wb_rd_addr(wb_rd_addr), .wb_WB(wb_WB), .wb_rd_data(wb_rd_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_stall(mem_stall), .load_use_stall(load_use_stall)
`ifdef BACKEND_PERF_CNT_EN
    , .perf_mem_wait(perf_mem_wait), .perf_load_use(perf_load_use)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_rd_addr = 0; ex_WB = 0; ex_M = 0;
    ex_alu_result = 0; ex_rs2_data = 0; ex_pc4 = 0;
    id_rs1_addr = 0; id_rs2_addr = 0;
  endtask

  task automatic ex_drive(input logic [4:0] rd, input logic [2:0] wb, input logic [1:0] m,
                          input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4);
    ex_valid = 1; ex_rd_addr = rd; ex_WB = wb; ex_M = m;
    ex_alu_result = alu; ex_rs2_data = rs2; ex_pc4 = pc4;
  endtask

  initial begin
    rstn = 0; ex_idle(); dmem_ready = 1; dmem_rdata = 0;
    tick(); tick();
    chk("rst_mem_rd", {27'd0, mem_rd_addr}, 0);
    chk("rst_mem_wb", {29'd0, mem_WB}, 0);
    chk("rst_wb_wb", {29'd0, wb_WB}, 0);
    chk("rst_rf_we", {31'd0, rf_we}, 0);
    chk("rst_req", {31'd0, dmem_req}, 0);
    chk("rst_stall", {30'd0, mem_stall, load_use_stall}, 0);
    rstn = 1;
    tick();

    // ALU op rd=5: EX/MEM next edge, register file write the edge after.
    ex_drive(5'd5, 3'b100, 2'b00, 32'h0000_1234, 0, 32'h44);
    tick(); ex_idle(); #1;
    chk("alu_mem_rd", {27'd0, mem_rd_addr}, 5);
    chk("alu_mem_wb", {29'd0, mem_WB}, 3'b100);
    chk("alu_mem_res", mem_alu_result, 32'h1234);
    chk("alu_req", {31'd0, dmem_req}, 0);
    tick();
    chk("alu_wb_rd", {27'd0, wb_rd_addr}, 5);
    chk("alu_rf_we", {31'd0, rf_we}, 1);
    chk("alu_rf_wdata", rf_wdata, 32'h1234);
    tick();
    chk("alu_rf_we_after", {31'd0, rf_we}, 0);

    // Load-use detection, combinational.
    ex_drive(5'd3, 3'b101, 2'b10, 32'h0, 0, 0);
    id_rs1_addr = 3; #1;
    chk("lu_rs1_hit", {31'd0, load_use_stall}, 1);
    id_rs1_addr = 0; id_rs2_addr = 3; #1;
    chk("lu_rs2_hit", {31'd0, load_use_stall}, 1);
    id_rs2_addr = 0; #1;
    chk("lu_rs0", {31'd0, load_use_stall}, 0);
    ex_rd_addr = 0; #1;
    chk("lu_rd0", {31'd0, load_use_stall}, 0);
    ex_rd_addr = 3; id_rs1_addr = 3; ex_M = 2'b00; #1;
    chk("lu_not_load", {31'd0, load_use_stall}, 0);
    ex_idle(); #1;

    // Load with three wait cycles.
    dmem_ready = 0;
    ex_drive(5'd7, 3'b101, 2'b10, 32'h200, 0, 0);
    tick(); ex_idle(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_req", {31'd0, dmem_req}, 1);
      chk("lw_we", {31'd0, dmem_we}, 0);
      chk("lw_addr", dmem_addr, 32'h200);
      chk("lw_stall", {31'd0, mem_stall}, 1);
      chk("lw_bubble", {31'd0, rf_we}, 0);
      tick();
    end
    dmem_ready = 1; dmem_rdata = 32'hCAFE_F00D; #1;
    chk("lw_ready_stall", {31'd0, mem_stall}, 0);
    chk("lw_ready_req", {31'd0, dmem_req}, 1);
    tick(); dmem_rdata = 32'h0; #1;
    chk("lw_wb_rd", {27'd0, wb_rd_addr}, 7);
    chk("lw_wb_data", wb_rd_data, 32'hCAFE_F00D);
    chk("lw_rf_we", {31'd0, rf_we}, 1);
    chk("lw_req_done", {31'd0, dmem_req}, 0);

    // Store with immediate ready.
    ex_drive(5'd0, 3'b000, 2'b01, 32'h100, 32'hDEAD_BEEF, 0);
    tick(); ex_idle(); #1;
    chk("sw_req", {31'd0, dmem_req}, 1);
    chk("sw_we", {31'd0, dmem_we}, 1);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    chk("sw_stall", {31'd0, mem_stall}, 0);
    tick();
    chk("sw_we_after", {31'd0, dmem_we}, 0);
    chk("sw_rf_we", {31'd0, rf_we}, 0);

    // jal: link value selected for writeback.
    ex_drive(5'd1, 3'b110, 2'b00, 32'h999, 0, 32'h1004);
    tick(); ex_idle(); tick();
    chk("jal_wb_data", wb_rd_data, 32'h1004);
    chk("jal_rf_waddr", {27'd0, rf_waddr}, 1);
    chk("jal_rf_we", {31'd0, rf_we}, 1);

    // Load-use during memory wait is masked, then reset mid-WAIT.
    dmem_ready = 0;
    ex_drive(5'd8, 3'b101, 2'b10, 32'h300, 0, 0);
    tick();
    ex_drive(5'd9, 3'b101, 2'b10, 32'h304, 0, 0);
    id_rs1_addr = 9; #1;
    chk("mix_stall", {31'd0, mem_stall}, 1);
    chk("mix_lu_masked", {31'd0, load_use_stall}, 0);
    tick();
    chk("wait_stall", {31'd0, mem_stall}, 1);
    chk("wait_addr", dmem_addr, 32'h300);
    dmem_ready = 1; #1;
    chk("mix_lu_unmasked", {31'd0, load_use_stall}, 1);
    dmem_ready = 0; #1;
    ex_idle();
    rstn = 0; #1;
    chk("arst_req", {31'd0, dmem_req}, 0);
    chk("arst_stall", {31'd0, mem_stall}, 0);
    chk("arst_mem_rd", {27'd0, mem_rd_addr}, 0);
    chk("arst_addr", dmem_addr, 0);
    chk("arst_wb", {29'd0, wb_WB}, 0);
    tick();
    rstn = 1;
    tick();
    chk("post_rst_req", {31'd0, dmem_req}, 0);
    chk("post_rst_stall", {31'd0, mem_stall}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
